// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//
// Parametrised register file: NREG registers of WIDTH bits that sit between the
// ALU system bus (I) and the ALU/MUX operand inputs (OutA/OutB). Every register
// whose active-low RegSel bit is low applies the shared FunSel operation to its
// own current value. Each register carries a sticky wrap flag that records an
// increment past all-ones or a decrement past zero, for loop/pointer counters.
//
// Parameters
//   WIDTH    register width in bits (even, >= 4)
//   NREG     number of registers (power of 2, >= 2)
//   REG_OUT  0: combinational read ports
//            1: registered read ports with write bypass
//   SEL_W    read select width, derived from NREG
//
// Ports
//   Clock    in   1      rising-edge clock
//   Reset    in   1      asynchronous active-low reset
//   I        in   WIDTH  write data
//   FunSel   in   3      operation applied to every selected register
//   RegSel   in   NREG   active-low register select
//   OutASel  in   SEL_W  read port A index
//   OutBSel  in   SEL_W  read port B index
//   WrapClr  in   NREG   active-high wrap flag clear
//   OutA     out  WIDTH  read port A data
//   OutB     out  WIDTH  read port B data
//   Wrap     out  NREG   sticky wrap flags
// -----------------------------------------------------------------------------
module param_register_file #(
    parameter  int WIDTH   = 16,
    parameter  int NREG    = 8,
    parameter  int REG_OUT = 0,
    localparam int SEL_W   = $clog2(NREG)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [NREG-1:0]  RegSel,
    input  logic [SEL_W-1:0] OutASel,
    input  logic [SEL_W-1:0] OutBSel,
    input  logic [NREG-1:0]  WrapClr,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [NREG-1:0]  Wrap
);

    localparam int             H    = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  wrap_q;
    logic [NREG-1:0]  wrap_d;
    logic [NREG-1:0]  wrap_set;
    logic [NREG-1:0]  wrap_clr;

    always_comb begin
        wrap_set = '0;
        wrap_clr = WrapClr;
        for (int k = 0; k < NREG; k++) begin
            regs_d[k] = regs_q[k];
            if (!RegSel[k]) begin
                case (FunSel)
                    3'b000: begin
                        regs_d[k] = regs_q[k] - ONE;
                        if (regs_q[k] == '0) wrap_set[k] = 1'b1;
                    end
                    3'b001: begin
                        regs_d[k] = regs_q[k] + ONE;
                        if (regs_q[k] == ONES) wrap_set[k] = 1'b1;
                    end
                    3'b010: begin
                        regs_d[k]   = I;
                        wrap_clr[k] = 1'b1;
                    end
                    3'b011: begin
                        regs_d[k]   = '0;
                        wrap_clr[k] = 1'b1;
                    end
                    3'b100: begin
                        regs_d[k]   = {{(WIDTH-H){1'b0}}, I[H-1:0]};
                        wrap_clr[k] = 1'b1;
                    end
                    3'b101: regs_d[k] = {regs_q[k][WIDTH-1:H], I[H-1:0]};
                    3'b110: regs_d[k] = {I[H-1:0], regs_q[k][H-1:0]};
                    default: begin
                        regs_d[k]   = {{(WIDTH-H){I[H-1]}}, I[H-1:0]};
                        wrap_clr[k] = 1'b1;
                    end
                endcase
            end
        end
        // A wrap event in the same cycle as a clear keeps the flag set.
        wrap_d = wrap_set | (wrap_q & ~wrap_clr);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
            wrap_q <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
            wrap_q <= wrap_d;
        end
    end

    assign Wrap = wrap_q;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] out_a_q;
            logic [WIDTH-1:0] out_b_q;

            // Capturing next-state values gives write bypass: data written on
            // an edge is on the port right after that same edge.
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    out_a_q <= '0;
                    out_b_q <= '0;
                end else begin
                    out_a_q <= regs_d[OutASel];
                    out_b_q <= regs_d[OutBSel];
                end
            end

            assign OutA = out_a_q;
            assign OutB = out_b_q;
        end else begin : g_comb_out
            assign OutA = regs_q[OutASel];
            assign OutB = regs_q[OutBSel];
        end
    endgenerate

endmodule
